pio_debounce_irq: RTL and testbench

Parametrised general-purpose I/O peripheral with an Avalon-MM slave interface. It combines the button, DIP-switch and LED parallel ports into one block per channel group. Each input bit passes through a 2-flop synchroniser and a debounce filter, then feeds per-bit edge capture with an interrupt mask. Outputs support atomic set and clear writes. The block sits on the HPS lightweight bridge and replaces the plain PIO instances.

---
 rtl/pio_debounce_irq.sv | 165 ++++++++++++++++
 tb/tb_pio_debounce_irq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_debounce_irq.sv
// Purpose: Avalon-MM GPIO with synchronised, debounced inputs, per-bit edge capture/IRQ mask and set/clear outputs.
// Latency: pins reach IN_DATA 2+DB_CYCLES clocks after a change; out_export follows a write on the next edge; readdata 1 cycle.
// Backpressure: none -- no waitrequest, every read and write completes in the cycle it is presented.
module pio_debounce_irq #(
  parameter int               IN_W      = 4,
  parameter int               OUT_W     = 10,
  parameter int               DB_CYCLES = 50000,
  parameter logic [IN_W-1:0]  IN_RESET  = '0,
  parameter logic [OUT_W-1:0] OUT_RESET = '0
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  input  logic [IN_W-1:0]  in_export,
  output logic [OUT_W-1:0] out_export,
  output logic             irq
);

  // A single-cycle qualification still needs a one-bit counter to exist.
  localparam int              CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  localparam logic [2:0] ADDR_IN_DATA  = 3'd0;
  localparam logic [2:0] ADDR_OUT_DATA = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
  localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;
  localparam logic [2:0] ADDR_EDGE_POL = 3'd6;

  logic [IN_W-1:0]  sync_q1;
  logic [IN_W-1:0]  sync_q2;
  logic [IN_W-1:0]  stable_q;
  logic [CNT_W-1:0] cnt_q [IN_W];
  logic [IN_W-1:0]  differ;
  logic [IN_W-1:0]  accept;
  logic [IN_W-1:0]  edge_set;
  logic [IN_W-1:0]  edge_clr;
  logic [IN_W-1:0]  irq_mask_q;
  logic [IN_W-1:0]  edge_cap_q;
  logic [IN_W-1:0]  edge_pol_q;
  logic [OUT_W-1:0] out_q;
  logic [31:0]      rd_mux;
  logic [IN_W-1:0]  wdata_in;
  logic [OUT_W-1:0] wdata_out;
  logic             wr_out_data;
  logic             wr_out_set;
  logic             wr_out_clr;
  logic             wr_irq_mask;
  logic             wr_edge_cap;
  logic             wr_edge_pol;
  logic             unused_wdata;

  // Bits above each register's width are dropped on write.
  assign wdata_in     = avs_writedata[IN_W-1:0];
  assign wdata_out    = avs_writedata[OUT_W-1:0];
  assign unused_wdata = ^avs_writedata;

  assign wr_out_data = avs_write && (avs_address == ADDR_OUT_DATA);
  assign wr_out_set  = avs_write && (avs_address == ADDR_OUT_SET);
  assign wr_out_clr  = avs_write && (avs_address == ADDR_OUT_CLR);
  assign wr_irq_mask = avs_write && (avs_address == ADDR_IRQ_MASK);
  assign wr_edge_cap = avs_write && (avs_address == ADDR_EDGE_CAP);
  assign wr_edge_pol = avs_write && (avs_address == ADDR_EDGE_POL);

  // Two-flop synchroniser for the raw asynchronous pins.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_q1 <= IN_RESET;
      sync_q2 <= IN_RESET;
    end else begin
      sync_q1 <= in_export;
      sync_q2 <= sync_q1;
    end
  end

  // A bit is accepted once it has disagreed with stable for DB_CYCLES consecutive clocks.
  always_comb begin
    differ = sync_q2 ^ stable_q;
    accept = '0;
    for (int i = 0; i < IN_W; i++) begin
      accept[i] = differ[i] && (cnt_q[i] == CNT_LAST);
    end
  end

  // Per-bit qualification counters; any agreement with stable restarts the count.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stable_q <= IN_RESET;
      for (int i = 0; i < IN_W; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_q ^ accept;
      for (int i = 0; i < IN_W; i++) begin
        if (!differ[i] || accept[i]) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // The accepted value is sync_q2; it matches the selected polarity when it differs from the pol bit
  // (new 1 with pol 0 = rising, new 0 with pol 1 = falling). Pol writes alone never create an edge.
  assign edge_set = accept & (sync_q2 ^ edge_pol_q);
  assign edge_clr = wr_edge_cap ? wdata_in : '0;

  // Interrupt control registers; a capture in the same cycle as a write-1-clear wins.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      irq_mask_q <= '0;
      edge_pol_q <= '0;
      edge_cap_q <= '0;
    end else begin
      if (wr_irq_mask) irq_mask_q <= wdata_in;
      if (wr_edge_pol) edge_pol_q <= wdata_in;
      edge_cap_q <= (edge_cap_q & ~edge_clr) | edge_set;
    end
  end

  // Output register with whole-word, atomic-set and atomic-clear write paths.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_q <= OUT_RESET;
    end else if (wr_out_data) begin
      out_q <= wdata_out;
    end else if (wr_out_set) begin
      out_q <= out_q | wdata_out;
    end else if (wr_out_clr) begin
      out_q <= out_q & ~wdata_out;
    end
  end

  // Read mux over pre-write register contents; unused and write-only addresses read as zero.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_IN_DATA:  rd_mux[IN_W-1:0]  = stable_q;
      ADDR_OUT_DATA: rd_mux[OUT_W-1:0] = out_q;
      ADDR_IRQ_MASK: rd_mux[IN_W-1:0]  = irq_mask_q;
      ADDR_EDGE_CAP: rd_mux[IN_W-1:0]  = edge_cap_q;
      ADDR_EDGE_POL: rd_mux[IN_W-1:0]  = edge_pol_q;
      default:       rd_mux            = '0;
    endcase
  end

  // Read data is registered and holds between reads.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rd_mux;
    end
  end

  assign out_export = out_q;
  assign irq        = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_pio_debounce_irq.sv
// Purpose: directed plus randomized bench for pio_debounce_irq against a sliding-window reference model.
// Latency: checks outputs 1 time unit after every rising clock edge.
// Backpressure: not applicable; the bus never stalls.
module tb_pio_debounce_irq;

  localparam int         IN_W    = 4;
  localparam int         OUT_W   = 10;
  localparam int         DB      = 8;
  localparam logic [3:0] IN_RST  = 4'hF;
  localparam logic [9:0] OUT_RST = 10'h155;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  addr;
  logic        rd;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  pins;
  logic [9:0]  outp;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0]  m_s1, m_s2, m_stable, m_mask, m_cap, m_pol;
  logic [9:0]  m_out;
  logic [31:0] m_rdata;
  logic [3:0]  win[$];   // last DB synchronised samples since reset

  pio_debounce_irq #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DB_CYCLES(DB), .IN_RESET(IN_RST), .OUT_RESET(OUT_RST)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(addr), .avs_read(rd), .avs_write(wr),
    .avs_writedata(wdata), .avs_readdata(rdata), .in_export(pins), .out_export(outp), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {28'b0, m_stable};
      3'd1:    return {22'b0, m_out};
      3'd2:    return {28'b0, m_mask};
      3'd3:    return {28'b0, m_cap};
      3'd6:    return {28'b0, m_pol};
      default: return 32'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_s1 = IN_RST; m_s2 = IN_RST; m_stable = IN_RST;
    m_mask = '0; m_cap = '0; m_pol = '0;
    m_out = OUT_RST; m_rdata = '0;
    win.delete();
  endtask

  // One clock edge of the model: a bit flips when every one of its last DB samples disagrees with stable.
  task automatic model_edge(input logic r_n, input logic [2:0] a, input logic r, input logic w,
                            input logic [31:0] d, input logic [3:0] p);
    logic [3:0] flips, set, clr, new_st;
    bit all_rev;
    if (!r_n) begin
      model_reset();
      return;
    end
    if (r) m_rdata = m_read(a);
    win.push_back(m_s2);
    if (win.size() > DB) void'(win.pop_front());
    flips = '0;
    if (win.size() == DB) begin
      for (int b = 0; b < 4; b++) begin
        all_rev = 1'b1;
        foreach (win[k]) if (win[k][b] == m_stable[b]) all_rev = 1'b0;
        flips[b] = all_rev;
      end
    end
    new_st = m_stable ^ flips;
    set = '0;
    for (int b = 0; b < 4; b++) begin
      if (flips[b] && (m_pol[b] ? !new_st[b] : new_st[b])) set[b] = 1'b1;
    end
    clr = '0;
    if (w) begin
      case (a)
        3'd1: m_out = d[9:0];
        3'd2: m_mask = d[3:0];
        3'd3: clr = d[3:0];
        3'd4: m_out = m_out | d[9:0];
        3'd5: m_out = m_out & ~d[9:0];
        3'd6: m_pol = d[3:0];
        default: ;
      endcase
    end
    m_cap = (m_cap & ~clr) | set;
    m_stable = new_st;
    m_s2 = m_s1;
    m_s1 = p;
  endtask

  task automatic tick();
    logic r_n, r, w;
    logic [2:0] a;
    logic [31:0] d;
    logic [3:0] p;
    r_n = rst_n; r = rd; w = wr; a = addr; d = wdata; p = pins;
    @(posedge clk);
    model_edge(r_n, a, r, w, d, p);
    #1;
    check("out_export", {22'b0, outp}, {22'b0, m_out});
    check("irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
    check("readdata", rdata, m_rdata);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] v);
    addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
    v = rdata;
  endtask

  // Reset asserted between edges, held across one edge, released just after it.
  task automatic pulse_reset();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_out", {22'b0, outp}, {22'b0, OUT_RST});
    check("async_rst_irq", {31'b0, irq}, 32'd0);
    check("async_rst_rdata", rdata, 32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    int hold;
    int op;
    rst_n = 1'b0; pins = 4'hF; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    model_reset();
    ticks(2);
    rst_n = 1'b1;

    // Reset values
    check("rst_out_export", {22'b0, outp}, 32'h155);
    check("rst_irq", {31'b0, irq}, 32'd0);
    bus_read(3'd0, v); check("rst_in_data", v, 32'hF);
    bus_read(3'd3, v); check("rst_edge_cap", v, 32'h0);

    // Falls with rising polarity selected capture nothing
    pins = 4'h0;
    ticks(12);
    bus_read(3'd0, v); check("in_data_low", v, 32'h0);
    bus_read(3'd3, v); check("fall_ignored", v, 32'h0);

    // Qualified rise on bit 0: exactly DB+2 edges after the pin change
    bus_write(3'd2, 32'h1);
    pins[0] = 1'b1;
    ticks(9);
    check("rise_not_yet", {31'b0, irq}, 32'd0);
    tick();
    check("rise_irq", {31'b0, irq}, 32'd1);
    bus_read(3'd3, v); check("rise_cap", v, 32'h1);
    bus_write(3'd3, 32'h1);
    check("w1c_irq", {31'b0, irq}, 32'd0);

    // Glitch of DB-1 clocks on bit 1 never qualifies
    pins[1] = 1'b1;
    ticks(DB - 1);
    pins[1] = 1'b0;
    ticks(12);
    bus_read(3'd0, v); check("glitch_in_data", v, 32'h1);
    bus_read(3'd3, v); check("glitch_cap", v, 32'h0);

    // Falling polarity: rise ignored, fall captured, pol change itself silent
    pins[0] = 1'b0;
    ticks(12);
    bus_write(3'd6, 32'h1);
    bus_read(3'd3, v); check("pol_change_no_edge", v, 32'h0);
    pins[0] = 1'b1;
    ticks(12);
    check("pol_rise_ignored", {31'b0, irq}, 32'd0);
    pins[0] = 1'b0;
    ticks(12);
    check("pol_fall_irq", {31'b0, irq}, 32'd1);
    bus_read(3'd3, v); check("pol_fall_cap", v, 32'h1);

    // Write-1-clear colliding with a new capture on bit 2: set wins
    bus_write(3'd3, 32'hF);
    bus_write(3'd6, 32'h0);
    pins[2] = 1'b1;
    ticks(9);
    addr = 3'd3; wdata = 32'h4; wr = 1'b1;
    tick();
    wr = 1'b0;
    bus_read(3'd3, v); check("set_beats_clear", v, 32'h4);

    // Output data, set and clear
    bus_write(3'd1, 32'h0F0);
    bus_write(3'd4, 32'h003);
    check("out_set", {22'b0, outp}, 32'h0F3);
    bus_read(3'd1, v); check("out_set_read", v, 32'h0F3);
    bus_write(3'd5, 32'h030);
    check("out_clr", {22'b0, outp}, 32'h0C3);
    bus_read(3'd4, v); check("read_set_zero", v, 32'h0);
    bus_read(3'd7, v); check("read_rsvd_zero", v, 32'h0);
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_read(3'd1, v); check("rsvd_write_ignored", v, 32'h0C3);

    // Reset in mid-qualification: a full DB count is needed after release
    pins = 4'hF;
    ticks(12);
    pins[3] = 1'b0;
    ticks(6);
    pulse_reset();
    bus_write(3'd2, 32'h8);
    bus_write(3'd6, 32'h8);
    ticks(7);
    check("rst_requal_not_yet", {31'b0, irq}, 32'd0);
    tick();
    check("rst_requal_irq", {31'b0, irq}, 32'd1);

    // Randomized traffic against the model
    hold = 0;
    for (int it = 0; it < 1500; it++) begin
      if (it == 700) pulse_reset();
      if (hold == 0) begin
        pins = pins ^ 4'($urandom_range(1, 15));
        hold = int'($urandom_range(1, 2 * DB + 4));
      end
      hold--;
      op = int'($urandom_range(0, 9));
      addr = 3'($urandom_range(0, 7));
      wdata = $urandom();
      rd = (op <= 2) || (op == 6);
      wr = (op >= 3) && (op <= 6);
      tick();
      rd = 1'b0;
      wr = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
